// File: rtl/ct_f_spsram_param.sv
// ct_f_spsram_param: parametrised single-port SRAM with clear-on-reset; define CT_F_SPSRAM_WRITE_THROUGH_EN for write-through Q
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 144,
  parameter int MASK_GRAN = 1,
  parameter int RD_LATENCY = 1,
  parameter int INIT_ON_RESET = 1,
  localparam int NL = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [NL-1:0]         WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);
  typedef enum logic [1:0] {S_RST, S_CLR, S_RDY} st_t;
  st_t st, st_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q1, q2, rdat;
  logic v1, clr, urd, uwr, fire;
  assign clr = !RST && INIT_ON_RESET != 0 && st != S_RDY;
  assign urd = !RST && st == S_RDY && !CEN && GWEN;
  assign uwr = !RST && st == S_RDY && !CEN && !GWEN;
`ifdef CT_F_SPSRAM_WRITE_THROUGH_EN
  logic [DATA_WIDTH-1:0] bm;
  for (genvar k = 0; k < NL; k++) begin : g_bm
    assign bm[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{~WEN[k]}};
  end
  assign fire = urd || uwr;
  assign rdat = uwr ? (mem[A] & ~bm) | (D & bm) : mem[A];
`else
  assign fire = urd;
  assign rdat = mem[A];
`endif
  always_comb begin
    st_nx = st == S_RST ? (INIT_ON_RESET != 0 ? S_CLR : S_RDY) : (st == S_CLR && cnt == '1) ? S_RDY : st;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= S_RST;
      cnt <= '0;
    end else begin
      st <= st_nx;
      if (clr) cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (clr) mem[cnt] <= '0;
    else if (uwr)
      for (int k = 0; k < NL; k++)
        if (!WEN[k]) mem[A][k*MASK_GRAN +: MASK_GRAN] <= D[k*MASK_GRAN +: MASK_GRAN];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      q1 <= '0;
      q2 <= '0;
      v1 <= 1'b0;
    end else begin
      if (fire) q1 <= rdat;
      v1 <= fire;
      if (v1) q2 <= q1;
    end
  end
  assign Q = RD_LATENCY == 2 ? q2 : q1;
  assign INIT_BUSY = st != S_RDY;
endmodule

// File: tb/tb_ct_f_spsram_param.sv
// tb_ct_f_spsram_param: random and directed checks of ct_f_spsram_param against an array-level model
module tb_ct_f_spsram_param;
`ifdef CT_F_SPSRAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST = 1'b1;
  logic [3:0] A = '0;
  logic CEN = 1'b1, GWEN = 1'b1;
  logic [3:0] WEN = '1;
  logic [31:0] D = '0;
  logic [31:0] Q1, Q2, Q0;
  logic B1, B2, B0;
  ct_f_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .RD_LATENCY(1), .INIT_ON_RESET(1)) u1 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q1), .INIT_BUSY(B1));
  ct_f_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .RD_LATENCY(2), .INIT_ON_RESET(1)) u2 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q2), .INIT_BUSY(B2));
  ct_f_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MASK_GRAN(8), .RD_LATENCY(1), .INIT_ON_RESET(0)) u0 (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q0), .INIT_BUSY(B0));
  int n_chk = 0, n_pass = 0;
  logic [31:0] mm [16];
  int rem = 16, rem0 = 1;
  logic [31:0] q1e = '0, q2e = '0, pd = '0;
  bit pv = 1'b0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc();
    logic [31:0] v, bm;
    bit rdy, rd, wr;
    rdy = rem == 0 && !RST;
    rd = rdy && !CEN && GWEN;
    wr = rdy && !CEN && !GWEN;
    for (int k = 0; k < 4; k++) bm[k*8 +: 8] = WEN[k] ? 8'h00 : 8'hff;
    v = rd ? mm[A] : (mm[A] & ~bm) | (D & bm);
    if (RST) begin
      rem = 16; rem0 = 1; q1e = '0; q2e = '0; pv = 1'b0;
    end else begin
      if (pv) q2e = pd;
      pv = rd || (WT && wr);
      if (pv) begin pd = v; q1e = v; end
      if (wr) mm[A] = v;
      if (rem0 > 0) rem0--;
      if (rem > 0) begin
        rem--;
        if (rem == 0) for (int i = 0; i < 16; i++) mm[i] = '0;
      end
    end
    @(posedge CLK);
    #1;
    check("busy_l1", B1, rem != 0);
    check("busy_l2", B2, rem != 0);
    check("busy_noinit", B0, rem0 != 0);
    check("q_l1", Q1, q1e);
    check("q_l2", Q2, q2e);
  endtask
  task automatic acc(bit c, bit g, logic [3:0] a, logic [31:0] d, logic [3:0] w);
    CEN = c; GWEN = g; A = a; D = d; WEN = w;
    cyc();
  endtask
  task automatic wr(logic [3:0] a, logic [31:0] d, logic [3:0] w); acc(1'b0, 1'b0, a, d, w); endtask
  task automatic rd(logic [3:0] a); acc(1'b0, 1'b1, a, '0, '1); endtask
  task automatic idle(); acc(1'b1, 1'b1, '0, '0, '1); endtask
  task automatic clr_wait(output int n);
    n = 0;
    do begin cyc(); n++; end while (B1 && n < 40);
  endtask
  initial begin
    int n;
    RST = 1'b1;
    repeat (3) cyc();
    check("q_rst", Q1, 32'h0);
    check("q0_rst", Q0, 32'h0);
    RST = 1'b0;
    clr_wait(n);
    check("clr_len", n, 16);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(); idle();
    RST = 1'b1; cyc(); RST = 1'b0;
    repeat (7) cyc();
    RST = 1'b1; cyc(); RST = 1'b0;
    clr_wait(n);
    check("clr_len_mid", n, 16);
    wr(4'd5, 32'hAABBCCDD, 4'b0000);
    wr(4'd5, 32'h11223344, 4'b1010);
    rd(4'd5);
    check("mask_l1", Q1, 32'hAA22CC44);
    idle();
    check("mask_l2", Q2, 32'hAA22CC44);
    wr(4'd1, 32'h1, 4'b0); wr(4'd2, 32'h2, 4'b0); wr(4'd3, 32'h3, 4'b0);
    rd(4'd1); rd(4'd2);
    check("b2b_0", Q2, 32'h1);
    rd(4'd3);
    check("b2b_1", Q2, 32'h2);
    idle();
    check("b2b_2", Q2, 32'h3);
    idle();
    check("b2b_hold", Q2, 32'h3);
    wr(4'd9, 32'h5A, 4'b0);
    rd(4'd9);
    check("waw_l1", Q1, 32'h5A);
    idle();
    check("waw_l2", Q2, 32'h5A);
    wr(4'd4, 32'h77, 4'b0);
    check("wt_l1", Q1, WT ? 32'h77 : 32'h5A);
    idle();
    check("wt_l2", Q2, WT ? 32'h77 : 32'h5A);
    RST = 1'b1; cyc(); RST = 1'b0;
    CEN = 1'b0; GWEN = 1'b0; A = 4'd2; D = 32'hFF; WEN = 4'b0;
    clr_wait(n);
    idle();
    rd(4'd2);
    check("busy_drop", Q1, 32'h0);
    repeat (3000) begin
      RST = $urandom_range(0, 299) == 0;
      acc($urandom_range(0, 2) == 0, 1'($urandom), 4'($urandom), $urandom, 4'($urandom));
    end
    RST = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ct_f_spsram_param.md
Name: ct_f_spsram_param

Overview:
- Parametrised FPGA single-port SRAM model; the next generation of the fixed-size ct_f_spsram_* wrappers.
- Generic depth and width, configurable write-mask granularity, and a selectable 1- or 2-cycle read pipeline.
- Hardware clear-on-reset sequencer, so the array holds known contents before use.
- Sits under the L1/L2 tag/data array wrappers in the FPGA build; drop-in pin-compatible with the existing A/CEN/D/GWEN/WEN/Q convention, plus RST and INIT_BUSY.

Parameters:
- ADDR_WIDTH, 9: address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 144: word width in bits.
- MASK_GRAN, 1: data bits per WEN lane; DATA_WIDTH must be a multiple of MASK_GRAN; lanes NL = DATA_WIDTH/MASK_GRAN.
- RD_LATENCY, 1: cycles from read request to Q valid; legal values 1 or 2 (2 adds an output register).
- INIT_ON_RESET, 1: 1 = clear the whole array to zero after reset; 0 = no clear, contents undefined.

Ports:
- CLK, input, 1: single clock; all logic on posedge.
- RST, input, 1: synchronous, active-high reset.
- A, input, ADDR_WIDTH: word address.
- CEN, input, 1: chip enable, active low.
- GWEN, input, 1: global write enable, active low (0 = write, 1 = read).
- WEN, input, NL: per-lane write enable, active low; lane k covers D[k*MASK_GRAN +: MASK_GRAN].
- D, input, DATA_WIDTH: write data.
- Q, output, DATA_WIDTH: read data.
- INIT_BUSY, output, 1: high while reset or the clear sequence is active; user accesses are ignored while high.

Behaviour:
- Reset values: while RST=1, Q=0, INIT_BUSY=1, clear counter=0 and FSM=S_RST. The array is not written during reset.
- FSM states:
  - S_RST -> S_CLR on the first cycle with RST=0 if INIT_ON_RESET=1; otherwise S_RST -> S_RDY.
  - S_CLR: write all-zero to address cnt, all lanes enabled, then cnt++. When cnt = 2^ADDR_WIDTH-1 is written, go to S_RDY.
  - S_RDY: normal operation; INIT_BUSY=0.
- Clear timing: INIT_BUSY falls exactly 2^ADDR_WIDTH cycles after RST deasserts (INIT_ON_RESET=1), or 1 cycle after (INIT_ON_RESET=0).
- RST=1 in any state, including mid-clear, returns to S_RST and restarts the clear from address 0.
- Accesses during INIT_BUSY=1 are dropped: no write, Q unchanged, no error indication.
- Read: request is CEN=0, GWEN=1 at edge N.
  - RD_LATENCY=1: Q = mem[A] after edge N+1.
  - RD_LATENCY=2: Q = mem[A] after edge N+2.
  - Back-to-back reads are pipelined, one per cycle.
- Q hold: Q keeps the last read data whenever no read completes that cycle (idle, write, or busy cycles). This is equivalent to the holding-address scheme.
- Write: CEN=0, GWEN=0 at edge N updates lanes with WEN[k]=0 to D's lane. Lanes with WEN[k]=1 keep their old value. WEN all-ones is a legal no-op write.
- Same-address read on the cycle after a write returns the new data: no read-during-write hazard across cycles.
- Address width: A is used as-is; there is no out-of-range case.
- Q is registered by the RAM primitive (RD_LATENCY=1) or by an extra flop stage (RD_LATENCY=2). Q has no combinational path from inputs.

Optional Feature:
- Macro: CT_F_SPSRAM_WRITE_THROUGH_EN.
- Defined: a user write also produces Q after RD_LATENCY cycles. Q equals the post-write word: written lanes take D, masked lanes take the old contents, using a read-first primitive plus a registered merge of D/WEN.
- Undefined: a write leaves Q holding its previous value, as above.
- Clear-sequence writes never update Q in either build.

Test Plan:
- INIT_ON_RESET=1, ADDR_WIDTH=4: hold RST 3 cycles, release -> INIT_BUSY=1 for exactly 16 cycles then 0. Reads of addr 0..15 return 0; Q=0 throughout.
- Reset mid-clear: assert RST at clear cycle 7 for 1 cycle -> counter restarts; INIT_BUSY falls 16 cycles after the second RST release.
- MASK_GRAN=8, DATA_WIDTH=32: write 0xAABBCCDD to addr 5, then write 0x11223344 with WEN=4'b1010. Read addr 5 -> 0xAA22CC44.
- RD_LATENCY=2: back-to-back reads of addr 1 (0x1), addr 2 (0x2), addr 3 (0x3) -> Q=0x1,0x2,0x3 on cycles N+2..N+4. With CEN=1 afterwards, Q holds 0x3.
- Write-after-write/read: write addr 9 = 0x5A, read addr 9 next cycle -> Q=0x5A after RD_LATENCY. A write to addr 4 leaves Q=0x5A (macro off), or Q=new addr-4 word (macro on).
- Busy drop: during INIT_BUSY, issue write addr 2 = 0xFF -> after clear, read addr 2 returns 0.
